mem_arbiter: RTL and testbench

Two-master AHB-Lite arbiter that shares the single on-chip BSRAM memory interface slave between the core's instruction-fetch port (M0) and load/store port (M1). It sits between the two core bus masters and the memory interface's AHB slave port. Uncontended transfers pass through with no added latency. A transfer that loses arbitration is captured, and its master is stalled through HREADY until the transfer completes on the slave.

---
 rtl/mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master AHB-Lite arbiter sharing one slave port between
// the instruction-fetch master (M0) and the load/store master (M1).
// Uncontended transfers pass straight through. A request that cannot be
// issued is held, and its master is stalled through HREADY until the
// transfer completes on the slave.
// Optional build macro MEM_ARB_FIXED_PRIO_EN: fresh-request ties always go to
// M1 instead of round-robin. Held-request priority is not affected.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int WORD_WIDTH = 32
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic [ADDR_WIDTH-1:0] m0_haddr,
    input  logic [1:0]            m0_htrans,
    input  logic                  m0_hwrite,
    input  logic [2:0]            m0_hsize,
    input  logic [WORD_WIDTH-1:0] m0_hwdata,
    output logic [WORD_WIDTH-1:0] m0_hrdata,
    output logic                  m0_hready,
    output logic                  m0_hresp,
    input  logic [ADDR_WIDTH-1:0] m1_haddr,
    input  logic [1:0]            m1_htrans,
    input  logic                  m1_hwrite,
    input  logic [2:0]            m1_hsize,
    input  logic [WORD_WIDTH-1:0] m1_hwdata,
    output logic [WORD_WIDTH-1:0] m1_hrdata,
    output logic                  m1_hready,
    output logic                  m1_hresp,
    output logic [ADDR_WIDTH-1:0] s_haddr,
    output logic [1:0]            s_htrans,
    output logic                  s_hwrite,
    output logic [2:0]            s_hsize,
    output logic [WORD_WIDTH-1:0] s_hwdata,
    input  logic [WORD_WIDTH-1:0] s_hrdata,
    input  logic                  s_hready,
    input  logic                  s_hresp
);

    localparam logic [1:0] HT_IDLE   = 2'b00;
    localparam logic [1:0] HT_NONSEQ = 2'b10;
    localparam logic [1:0] HT_SEQ    = 2'b11;

    logic [ADDR_WIDTH-1:0] m_haddr [2];
    logic [1:0]            m_htrans [2];
    logic [2:0]            m_hsize [2];
    logic [1:0]            m_hwrite;

    assign m_haddr[0]  = m0_haddr;
    assign m_haddr[1]  = m1_haddr;
    assign m_htrans[0] = m0_htrans;
    assign m_htrans[1] = m1_htrans;
    assign m_hsize[0]  = m0_hsize;
    assign m_hsize[1]  = m1_hsize;
    assign m_hwrite    = {m1_hwrite, m0_hwrite};

    logic [1:0]            hold_vld;
    logic [ADDR_WIDTH-1:0] hold_addr [2];
    logic [1:0]            hold_write;
    logic [2:0]            hold_size [2];
    logic                  dp_vld;
    logic                  dp_own;
    logic                  rr_last;

    logic [1:0] hready;
    logic [1:0] fresh;
    logic       issue;
    logic       sel;
    logic       from_hold;
    logic       tie;

`ifdef MEM_ARB_FIXED_PRIO_EN
    assign tie = 1'b1;
`else
    assign tie = ~rr_last;
`endif

    // Per-master ready: the data-phase owner follows the slave, a held master stalls
    always_comb begin
        hready = '0;
        fresh  = '0;
        for (int n = 0; n < 2; n++) begin
            hready[n] = (dp_vld && dp_own == 1'(n)) ? s_hready : !hold_vld[n];
            fresh[n]  = hready[n] && (m_htrans[n] == HT_NONSEQ || m_htrans[n] == HT_SEQ);
        end
    end

    // Slot selection: a held request beats fresh ones; fresh ties use the tie-break
    always_comb begin
        issue     = 1'b0;
        sel       = 1'b0;
        from_hold = 1'b0;
        if (s_hready) begin
            if (|hold_vld) begin
                issue     = 1'b1;
                from_hold = 1'b1;
                sel       = (&hold_vld) ? ~rr_last : hold_vld[1];
            end else if (|fresh) begin
                issue = 1'b1;
                sel   = (&fresh) ? tie : fresh[1];
            end
        end
    end

    assign s_htrans = issue ? HT_NONSEQ : HT_IDLE;
    assign s_haddr  = from_hold ? hold_addr[sel]  : m_haddr[sel];
    assign s_hwrite = from_hold ? hold_write[sel] : m_hwrite[sel];
    assign s_hsize  = from_hold ? hold_size[sel]  : m_hsize[sel];
    assign s_hwdata = dp_own ? m1_hwdata : m0_hwdata;

    assign m0_hready = hready[0];
    assign m1_hready = hready[1];
    assign m0_hrdata = (dp_vld && !dp_own) ? s_hrdata : '0;
    assign m1_hrdata = (dp_vld &&  dp_own) ? s_hrdata : '0;
    assign m0_hresp  = dp_vld && !dp_own && s_hresp;
    assign m1_hresp  = dp_vld &&  dp_own && s_hresp;

    // Data-phase tracker and round-robin pointer advance with each open slot
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dp_vld  <= 1'b0;
            dp_own  <= 1'b0;
            rr_last <= 1'b1;
        end else begin
            if (s_hready) begin
                dp_vld <= issue;
                dp_own <= sel;
            end
            if (issue)
                rr_last <= sel;
        end
    end

    // Hold registers capture fresh requests that miss the slot and clear when issued
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int n = 0; n < 2; n++) begin
                hold_vld[n]   <= 1'b0;
                hold_addr[n]  <= '0;
                hold_write[n] <= 1'b0;
                hold_size[n]  <= '0;
            end
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (fresh[n] && !(issue && sel == 1'(n))) begin
                    hold_vld[n]   <= 1'b1;
                    hold_addr[n]  <= m_haddr[n];
                    hold_write[n] <= m_hwrite[n];
                    hold_size[n]  <= m_hsize[n];
                end else if (issue && from_hold && sel == 1'(n)) begin
                    hold_vld[n] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector table plus hand sequences for mem_arbiter.
module tb_mem_arbiter;

    localparam logic [1:0]  I = 2'b00;
    localparam logic [1:0]  N = 2'b10;
    localparam logic [31:0] Z = '0;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic [31:0] m0_haddr, m1_haddr, m0_hwdata, m1_hwdata, m0_hrdata, m1_hrdata;
    logic [1:0]  m0_htrans, m1_htrans, s_htrans;
    logic        m0_hwrite, m1_hwrite, m0_hready, m1_hready, m0_hresp, m1_hresp;
    logic [2:0]  m0_hsize, m1_hsize, s_hsize;
    logic [31:0] s_haddr, s_hwdata, s_hrdata;
    logic        s_hwrite, s_hready, s_hresp;

    int checks = 0;
    int errors = 0;

    always #5 HCLK = ~HCLK;

    mem_arbiter #(.ADDR_WIDTH(32), .WORD_WIDTH(32)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .m0_haddr(m0_haddr), .m0_htrans(m0_htrans), .m0_hwrite(m0_hwrite),
        .m0_hsize(m0_hsize), .m0_hwdata(m0_hwdata), .m0_hrdata(m0_hrdata),
        .m0_hready(m0_hready), .m0_hresp(m0_hresp),
        .m1_haddr(m1_haddr), .m1_htrans(m1_htrans), .m1_hwrite(m1_hwrite),
        .m1_hsize(m1_hsize), .m1_hwdata(m1_hwdata), .m1_hrdata(m1_hrdata),
        .m1_hready(m1_hready), .m1_hresp(m1_hresp),
        .s_haddr(s_haddr), .s_htrans(s_htrans), .s_hwrite(s_hwrite),
        .s_hsize(s_hsize), .s_hwdata(s_hwdata), .s_hrdata(s_hrdata),
        .s_hready(s_hready), .s_hresp(s_hresp)
    );

    typedef struct {
        logic [1:0]  m0t;
        logic [31:0] m0a;
        logic [1:0]  m1t;
        logic [31:0] m1a;
        logic        m1w;
        logic [31:0] m1wd;
        logic        shr;
        logic        srsp;
        logic [31:0] srd;
        logic [1:0]  st;
        logic [31:0] sa;
        logic        sw;
        logic [2:0]  ssz;
        logic        h0;
        logic        h1;
        logic [31:0] rd0;
        logic [31:0] rd1;
        logic        r0;
        logic        r1;
        logic        cwd;
        logic [31:0] swd;
    } vec_t;

    vec_t vecs [19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] t0, input logic [31:0] a0,
                         input logic [1:0] t1, input logic [31:0] a1, input logic w1,
                         input logic [31:0] wd1, input logic shr, input logic srsp,
                         input logic [31:0] srd);
        m0_htrans = t0;
        m0_haddr  = a0;
        m1_htrans = t1;
        m1_haddr  = a1;
        m1_hwrite = w1;
        m1_hwdata = wd1;
        s_hready  = shr;
        s_hresp   = srsp;
        s_hrdata  = srd;
    endtask

    initial begin
        // inputs, slave response | s_htrans, s_haddr, s_hwrite, s_hsize, hready0/1, hrdata0/1, hresp0/1, check hwdata
        vecs[0]  = '{I,Z,I,Z,'0,Z,'1,'0,32'h11,          I,Z,'0,3'd0,'1,'1,Z,Z,'0,'0,'0,Z};
        vecs[1]  = '{N,32'h100,N,32'h200,'1,Z,'1,'0,Z,    N,32'h100,'0,3'd2,'1,'1,Z,Z,'0,'0,'0,Z};
        vecs[2]  = '{I,Z,I,Z,'0,32'hDEADBEEF,'1,'0,32'h11110000,
                     N,32'h200,'1,3'd0,'1,'0,32'h11110000,Z,'0,'0,'1,32'h0C0C0C0C};
        vecs[3]  = '{I,Z,I,Z,'0,32'hDEADBEEF,'1,'0,32'h2222,
                     I,Z,'0,3'd0,'1,'1,Z,32'h2222,'0,'0,'1,32'hDEADBEEF};
        vecs[4]  = '{N,32'h300,N,32'h400,'0,Z,'1,'0,Z,    N,32'h300,'0,3'd2,'1,'1,Z,Z,'0,'0,'0,Z};
        vecs[5]  = '{N,32'h304,I,Z,'0,Z,'1,'0,32'h3333,   N,32'h400,'0,3'd0,'1,'0,32'h3333,Z,'0,'0,'0,Z};
        vecs[6]  = '{I,Z,N,32'h404,'0,Z,'1,'0,32'h4444,   N,32'h304,'0,3'd2,'0,'1,Z,32'h4444,'0,'0,'0,Z};
        vecs[7]  = '{I,Z,I,Z,'0,Z,'1,'0,32'h5050,         N,32'h404,'0,3'd0,'1,'0,32'h5050,Z,'0,'0,'0,Z};
        vecs[8]  = '{I,Z,I,Z,'0,Z,'1,'0,32'h6060,         I,Z,'0,3'd0,'1,'1,Z,32'h6060,'0,'0,'0,Z};
        vecs[9]  = '{I,Z,N,32'h500,'0,Z,'1,'0,32'h7070,   N,32'h500,'0,3'd0,'1,'1,Z,Z,'0,'0,'0,Z};
        vecs[10] = '{N,32'h600,I,Z,'0,Z,'0,'0,Z,          I,Z,'0,3'd0,'1,'0,Z,Z,'0,'0,'0,Z};
        vecs[11] = '{I,Z,I,Z,'0,Z,'0,'0,32'hAA,           I,Z,'0,3'd0,'0,'0,Z,32'hAA,'0,'0,'0,Z};
        vecs[12] = '{I,Z,I,Z,'0,Z,'0,'0,32'hBB,           I,Z,'0,3'd0,'0,'0,Z,32'hBB,'0,'0,'0,Z};
        vecs[13] = '{I,Z,I,Z,'0,Z,'1,'0,32'h5555,         N,32'h600,'0,3'd2,'0,'1,Z,32'h5555,'0,'0,'0,Z};
        vecs[14] = '{I,Z,I,Z,'0,Z,'1,'0,32'h6666,         I,Z,'0,3'd0,'1,'1,32'h6666,Z,'0,'0,'0,Z};
        vecs[15] = '{N,32'h700,I,Z,'0,Z,'1,'0,Z,          N,32'h700,'0,3'd2,'1,'1,Z,Z,'0,'0,'0,Z};
        vecs[16] = '{I,Z,N,32'h800,'0,Z,'0,'1,32'hE0,     I,Z,'0,3'd0,'0,'1,32'hE0,Z,'1,'0,'0,Z};
        vecs[17] = '{I,Z,I,Z,'0,Z,'1,'1,32'hE1,           N,32'h800,'0,3'd0,'1,'0,32'hE1,Z,'1,'0,'0,Z};
        vecs[18] = '{I,Z,I,Z,'0,Z,'1,'0,32'h8888,         I,Z,'0,3'd0,'1,'1,Z,32'h8888,'0,'0,'0,Z};

        m0_hwrite = 1'b0;
        m0_hsize  = 3'd2;
        m1_hsize  = 3'd0;
        m0_hwdata = 32'h0C0C0C0C;
        drive(I, Z, I, Z, 1'b0, Z, 1'b1, 1'b1, 32'hFFFF);

        repeat (2) @(posedge HCLK);
        #1;
        chk("reset s_htrans", {30'd0, s_htrans}, {30'd0, I});
        chk("reset m0_hready", {31'd0, m0_hready}, 32'd1);
        chk("reset m1_hready", {31'd0, m1_hready}, 32'd1);
        chk("reset m0_hresp", {31'd0, m0_hresp}, 32'd0);
        chk("reset m0_hrdata", m0_hrdata, Z);
        chk("reset m1_hrdata", m1_hrdata, Z);
        HRESETn = 1'b1;

        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].m0t, vecs[i].m0a, vecs[i].m1t, vecs[i].m1a, vecs[i].m1w,
                  vecs[i].m1wd, vecs[i].shr, vecs[i].srsp, vecs[i].srd);
            #3;
            chk($sformatf("v%0d s_htrans", i), {30'd0, s_htrans}, {30'd0, vecs[i].st});
            if (vecs[i].st == N) begin
                chk($sformatf("v%0d s_haddr", i), s_haddr, vecs[i].sa);
                chk($sformatf("v%0d s_hwrite", i), {31'd0, s_hwrite}, {31'd0, vecs[i].sw});
                chk($sformatf("v%0d s_hsize", i), {29'd0, s_hsize}, {29'd0, vecs[i].ssz});
            end
            chk($sformatf("v%0d m0_hready", i), {31'd0, m0_hready}, {31'd0, vecs[i].h0});
            chk($sformatf("v%0d m1_hready", i), {31'd0, m1_hready}, {31'd0, vecs[i].h1});
            chk($sformatf("v%0d m0_hrdata", i), m0_hrdata, vecs[i].rd0);
            chk($sformatf("v%0d m1_hrdata", i), m1_hrdata, vecs[i].rd1);
            chk($sformatf("v%0d m0_hresp", i), {31'd0, m0_hresp}, {31'd0, vecs[i].r0});
            chk($sformatf("v%0d m1_hresp", i), {31'd0, m1_hresp}, {31'd0, vecs[i].r1});
            if (vecs[i].cwd)
                chk($sformatf("v%0d s_hwdata", i), s_hwdata, vecs[i].swd);
            @(posedge HCLK);
            #1;
        end

        // Collision with pointer on M1: M0 wins, M1 held
        drive(N, 32'h900, N, 32'hA00, 1'b1, Z, 1'b1, 1'b0, Z);
        #3;
        chk("rst_seq tie s_haddr", s_haddr, 32'h900);
        @(posedge HCLK);
        #1;
        // Held M1 issuing; reset asserted mid-cycle abandons it
        drive(I, Z, I, Z, 1'b0, Z, 1'b1, 1'b0, 32'h9999);
        #3;
        chk("rst_seq held m1_hready", {31'd0, m1_hready}, 32'd0);
        chk("rst_seq held s_htrans", {30'd0, s_htrans}, {30'd0, N});
        chk("rst_seq owner m0_hrdata", m0_hrdata, 32'h9999);
        HRESETn = 1'b0;
        #1;
        chk("rst_seq async s_htrans", {30'd0, s_htrans}, {30'd0, I});
        chk("rst_seq async m0_hready", {31'd0, m0_hready}, 32'd1);
        chk("rst_seq async m1_hready", {31'd0, m1_hready}, 32'd1);
        chk("rst_seq async m0_hrdata", m0_hrdata, Z);
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        #3;
        chk("rst_seq cleared m1_hready", {31'd0, m1_hready}, 32'd1);
        chk("rst_seq cleared s_htrans", {30'd0, s_htrans}, {30'd0, I});
        @(posedge HCLK);
        #1;
        // Pointer back at its reset value: M0 wins again
        drive(N, 32'hB00, N, 32'hC00, 1'b0, Z, 1'b1, 1'b0, Z);
        #3;
        chk("rst_seq rr reset s_haddr", s_haddr, 32'hB00);
        @(posedge HCLK);
        #1;
        drive(I, Z, I, Z, 1'b0, Z, 1'b1, 1'b0, Z);
        #3;
        chk("rst_seq loser issued s_haddr", s_haddr, 32'hC00);
        chk("rst_seq loser m1_hready", {31'd0, m1_hready}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
